// File: rtl/rr_arb_mux.sv
// N-channel round-robin arbitrating mux with a single registered output stage.
// Optional RR_MUX_FIXED_PRIO_EN adds prio_mode (1 = fixed priority, channel 0 first).
module rr_arb_mux #(
    parameter int WIDTH = 32,
    parameter int N = 4,
    localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
`ifdef RR_MUX_FIXED_PRIO_EN
    input  logic                 prio_mode,
`endif
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    input  logic                 out_ready
);

    logic                 prio;
    logic                 load;
    logic                 found;
    logic [SELW-1:0]      ptr;
    logic [SELW-1:0]      start;
    logic [SELW-1:0]      grant;
    logic [SELW-1:0]      cand;
    logic [SELW-1:0]      next_ptr;
    logic [WIDTH-1:0]     ch_data [N];
    int                   idx;

`ifdef RR_MUX_FIXED_PRIO_EN
    assign prio = prio_mode;
`else
    assign prio = 1'b0;
`endif

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
    end

    assign load  = ~out_valid | out_ready;
    assign start = prio ? '0 : ptr;

    // Scan wraps modulo N, so non-power-of-2 N never visits an unused index.
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = 0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(start) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            cand = SELW'(idx);
            if (!found && in_valid[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    assign next_ptr = (int'(grant) == N - 1) ? '0 : grant + SELW'(1);

    always_comb begin
        in_ready = '0;
        if (reset && load && found) begin
            in_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (load) begin
            if (found) begin
                out_valid <= 1'b1;
                out_data  <= ch_data[grant];
                out_sel   <= grant;
                if (!prio) begin
                    ptr <= next_ptr;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: a 4-channel and a 3-channel instance, with
// expected beats queued by the stimulus and checked by per-instance monitors.
module tb_rr_arb_mux;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  sel;
    } beat_t;

    logic         clk;
    logic         reset;
    logic [3:0]   in_valid;
    logic [31:0]  d [4];
    logic [127:0] in_data;
    logic [3:0]   in_ready;
    logic         out_valid;
    logic [31:0]  out_data;
    logic [1:0]   out_sel;
    logic         out_ready;

    logic [2:0]   in_valid3;
    logic [7:0]   d3 [3];
    logic [23:0]  in_data3;
    logic [2:0]   in_ready3;
    logic         out_valid3;
    logic [7:0]   out_data3;
    logic [1:0]   out_sel3;
    logic         out_ready3;

`ifdef RR_MUX_FIXED_PRIO_EN
    logic         prio_mode;
    logic         prio_mode3;
`endif

    beat_t q4[$];
    beat_t q3[$];
    int checks;
    int passed;

    assign in_data  = {d[3], d[2], d[1], d[0]};
    assign in_data3 = {d3[2], d3[1], d3[0]};

    rr_arb_mux #(.WIDTH(32), .N(4)) u_dut (
`ifdef RR_MUX_FIXED_PRIO_EN
        .prio_mode (prio_mode),
`endif
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    rr_arb_mux #(.WIDTH(8), .N(3)) u_dut3 (
`ifdef RR_MUX_FIXED_PRIO_EN
        .prio_mode (prio_mode3),
`endif
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid3),
        .in_data   (in_data3),
        .in_ready  (in_ready3),
        .out_valid (out_valid3),
        .out_data  (out_data3),
        .out_sel   (out_sel3),
        .out_ready (out_ready3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push4(input logic [31:0] data, input logic [3:0] sel);
        beat_t b;
        b.data = data;
        b.sel  = sel;
        q4.push_back(b);
    endtask

    task automatic push3(input logic [7:0] data, input logic [3:0] sel);
        beat_t b;
        b.data = {24'h0, data};
        b.sel  = sel;
        q3.push_back(b);
    endtask

    // Monitors: a beat is consumed on the edge following a negedge where valid & ready.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (q4.size() == 0) begin
                checks++;
                $display("FAIL n4_unexpected_beat: got data %h sel %0d expected none", out_data, out_sel);
            end else begin
                beat_t b;
                b = q4.pop_front();
                chk("n4_beat_data", out_data, b.data);
                chk("n4_beat_sel", {30'h0, out_sel}, {28'h0, b.sel});
            end
        end
    end

    always @(negedge clk) begin
        if (reset && out_valid3 && out_ready3) begin
            if (q3.size() == 0) begin
                checks++;
                $display("FAIL n3_unexpected_beat: got data %h sel %0d expected none", out_data3, out_sel3);
            end else begin
                beat_t b;
                b = q3.pop_front();
                chk("n3_beat_data", {24'h0, out_data3}, b.data);
                chk("n3_beat_sel", {30'h0, out_sel3}, {28'h0, b.sel});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        passed = 0;
        reset = 1'b0;
        in_valid = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) d[i] = 32'hA0 + i;
        in_valid3 = 3'b000;
        out_ready3 = 1'b1;
        for (int i = 0; i < 3; i++) d3[i] = 8'h30 + 8'(i);
`ifdef RR_MUX_FIXED_PRIO_EN
        prio_mode = 1'b0;
        prio_mode3 = 1'b0;
`endif

        // Reset state, with inputs requesting
        tick();
        tick();
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_sel", {30'h0, out_sel}, 32'h0);
        chk("rst_in_ready", {28'h0, in_ready}, 32'h0);
        in_valid = 4'b0000;
        reset = 1'b1;
        tick();

        // Single request from ch2
        d[2] = 32'hDEADBEEF;
        in_valid = 4'b0100;
        #1;
        chk("single_in_ready", {28'h0, in_ready}, 32'h4);
        push4(32'hDEADBEEF, 4'd2);
        tick();
        chk("single_out_valid", {31'h0, out_valid}, 32'h1);
        in_valid = 4'b0000;
        d[2] = 32'hA2;
        tick();

        // Full contention, pointer now at 3
        in_valid = 4'b1111;
        push4(32'hA3, 4'd3);
        push4(32'hA0, 4'd0);
        push4(32'hA1, 4'd1);
        push4(32'hA2, 4'd2);
        push4(32'hA3, 4'd3);
        push4(32'hA0, 4'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("contention_no_bubble", {31'h0, out_valid}, 32'h1);
        end
        in_valid = 4'b0000;
        tick();
        chk("contention_drained", {31'h0, out_valid}, 32'h0);

        // Backpressure, pointer now at 1
        in_valid = 4'b1111;
        push4(32'hA1, 4'd1);
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_in_ready", {28'h0, in_ready}, 32'h0);
            chk("stall_out_sel", {30'h0, out_sel}, 32'h1);
            chk("stall_out_data", out_data, 32'hA1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("stall_release_in_ready", {28'h0, in_ready}, 32'h4);
        push4(32'hA2, 4'd2);
        tick();
        chk("stall_release_sel", {30'h0, out_sel}, 32'h2);
        in_valid = 4'b0000;
        tick();

        // Reset mid-stream, pointer now at 3
        d[3] = 32'h12345678;
        in_valid = 4'b1000;
        out_ready = 1'b0;
        tick();
        in_valid = 4'b1111;
        chk("pre_rst_sel", {30'h0, out_sel}, 32'h3);
        chk("pre_rst_data", out_data, 32'h12345678);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("midrst_out_data", out_data, 32'h0);
        chk("midrst_out_sel", {30'h0, out_sel}, 32'h0);
        chk("midrst_in_ready", {28'h0, in_ready}, 32'h0);
        out_ready = 1'b1;
        tick();
        chk("midrst_hold_in_ready", {28'h0, in_ready}, 32'h0);
        chk("midrst_hold_valid", {31'h0, out_valid}, 32'h0);
        reset = 1'b1;
        d[3] = 32'hA3;
        #1;
        chk("post_rst_in_ready", {28'h0, in_ready}, 32'h1);
        push4(32'hA0, 4'd0);
        tick();
        in_valid = 4'b0000;
        tick();

`ifdef RR_MUX_FIXED_PRIO_EN
        // Fixed priority holds the pointer (at 1 here)
        prio_mode = 1'b1;
        in_valid = 4'b1111;
        for (int i = 0; i < 4; i++) push4(32'hA0, 4'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("prio_sel0", {30'h0, out_sel}, 32'h0);
        end
        prio_mode = 1'b0;
        push4(32'hA1, 4'd1);
        push4(32'hA2, 4'd2);
        push4(32'hA3, 4'd3);
        push4(32'hA0, 4'd0);
        for (int i = 0; i < 4; i++) tick();
        in_valid = 4'b0000;
        tick();
`endif

        // Three-channel instance: wrap modulo 3
        in_valid3 = 3'b010;
        push3(8'h31, 4'd1);
        tick();
        in_valid3 = 3'b011;
        #1;
        chk("n3_wrap_in_ready", {29'h0, in_ready3}, 32'h1);
        push3(8'h30, 4'd0);
        tick();
        in_valid3 = 3'b111;
        push3(8'h31, 4'd1);
        push3(8'h32, 4'd2);
        push3(8'h30, 4'd0);
        for (int i = 0; i < 3; i++) tick();
        in_valid3 = 3'b000;
        tick();

        for (int i = 0; i < 20 && (q4.size() != 0 || q3.size() != 0); i++) tick();
        chk("n4_queue_empty", q4.size(), 32'h0);
        chk("n3_queue_empty", q3.size(), 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
Parametrised N-channel, WIDTH-bit registered arbitrating multiplexer. It succeeds the team's fixed 2/4-input combinational muxes for shared-resource paths, such as multiple requesters into one bus or memory port. Each input channel has a valid/ready handshake. A round-robin arbiter picks one channel per cycle and registers the winning beat into a single output stage with valid/ready backpressure.

Parameters:
WIDTH, 32, data width per channel
N, 4, number of input channels (1..16, any value, non-power-of-2 allowed)
SELW, max(1,$clog2(N)), width of channel index; derived, never overridden

Ports:
clk  input  1  sole clock, rising edge
reset  input  1  one clock; reset is asynchronous and active-low
in_valid  input  N  per-channel beat valid, bit i = channel i
in_data  input  N*WIDTH  channel i data at [i*WIDTH +: WIDTH]
in_ready  output  N  per-channel accept; one-hot or zero
out_valid  output  1  output register holds a beat
out_data  output  WIDTH  registered beat data
out_sel  output  SELW  channel index the held beat came from
out_ready  input  1  consumer accepts beat when out_valid=1

Behaviour:
- Reset (reset=0, async): out_valid=0, out_data=0, out_sel=0, rr pointer ptr=0; in_ready forced to all-zero while reset=0. Any held beat is discarded.
- load = ~out_valid | out_ready (output slot empty or draining this cycle).
- Arbitration is combinational:
  - Scan channels ptr, ptr+1, ..., wrapping modulo N (not modulo 2^SELW).
  - First channel with in_valid=1 is grant g.
  - in_ready[g]=load; all other bits 0.
  - No valid input gives in_ready=0.
- Clock edge, load=1, some valid: out_valid<=1, out_data<=in_data[g], out_sel<=g, ptr<=(g+1) mod N.
- Clock edge, load=1, none valid: out_valid<=0; out_data, out_sel, ptr hold.
- Clock edge, load=0 (stall): out_valid, out_data, out_sel, ptr all hold; in_ready=0.
- Latency: input handshake to out_valid is 1 cycle. Sustained throughput is 1 beat/cycle with out_ready=1.
- Simultaneous drain and fill (out_valid=1, out_ready=1, input valid) replaces the beat in the same edge with no bubble.
- out_ready while out_valid=0 is ignored.
- Producer rule: in_valid/in_data are stable until in_ready. Deasserting in_valid early is tolerated with no side effect.
- Fairness: a continuously valid channel waits at most N-1 grants.
- N=1: ptr constant 0. Block degenerates to a one-stage pipeline register with handshake.
- No X on outputs after reset under any legal stimulus.

Optional Feature:
Macro RR_MUX_FIXED_PRIO_EN.
- Defined: adds input port prio_mode (1 bit).
  - prio_mode=1: scan always starts at channel 0 (lowest index wins) and ptr is not updated.
  - prio_mode=0: round-robin exactly as above.
  - prio_mode may change any cycle and takes effect on that cycle's arbitration.
- Undefined: port absent, pure round-robin, no extra logic.

Test Plan:
- Reset mid-stream: out_valid=1, out_data=0x12345678, out_sel=3, pull reset=0 between edges -> out_valid=0, out_data=0, out_sel=0 immediately; in_ready=0000 until reset=1; first grant after release scans from channel 0.
- Single request: N=4, in_valid=0100, ch2 data=0xDEADBEEF, out_ready=1 -> in_ready=0100 same cycle; next cycle out_valid=1, out_data=0xDEADBEEF, out_sel=2; next grant scans from ch3.
- Full contention: in_valid=1111 held, ch i data=0xA0+i, out_ready=1 -> out_sel sequence 0,1,2,3,0,1 on consecutive cycles, out_data 0xA0..0xA3 repeating, no bubbles.
- Backpressure: after beat from ch1 loaded, out_ready=0 for 3 cycles with in_valid=1111 -> out_data/out_sel=1 stable, in_ready=0000 all 3 cycles; out_ready=1 -> ch2 granted, out_sel=2 next cycle.
- Non-power-of-2 wrap: N=3, ptr=2 (after ch1 grant), in_valid=011 -> ch0 granted (scan 2,0,1), out_sel=0, ptr becomes 1; out_sel never reaches 3.
- RR_MUX_FIXED_PRIO_EN defined, prio_mode=1, in_valid=1111 held, out_ready=1 -> out_sel=0 every cycle; switch prio_mode=0 -> next grants 0,1,2,3 (ptr was held at 0).
